// File: rtl/adma_dm_dst_axis_keep_if.sv
// AXI-Stream master bus of the DMA destination data mover.
// The master drives TID/TDEST/TDATA/TKEEP/TSTRB/TLAST/TVALID; the slave returns TREADY.
interface adma_dm_dst_axis_keep_if #(
  parameter int MST_ID_W       = 5,
  parameter int DST_TDEST_W    = 2,
  parameter int ATX_DST_DATA_W = 256
);
  localparam int BYTE_AMT = ATX_DST_DATA_W / 8;

  logic [MST_ID_W-1:0]       m_tid_o;
  logic [DST_TDEST_W-1:0]    m_tdest_o;
  logic [ATX_DST_DATA_W-1:0] m_tdata_o;
  logic [BYTE_AMT-1:0]       m_tkeep_o;
  logic [BYTE_AMT-1:0]       m_tstrb_o;
  logic                      m_tlast_o;
  logic                      m_tvalid_o;
  logic                      m_tready_i;

  modport master (
    output m_tid_o, m_tdest_o, m_tdata_o, m_tkeep_o, m_tstrb_o, m_tlast_o, m_tvalid_o,
    input  m_tready_i
  );

  modport slave (
    input  m_tid_o, m_tdest_o, m_tdata_o, m_tkeep_o, m_tstrb_o, m_tlast_o, m_tvalid_o,
    output m_tready_i
  );
endinterface

// File: rtl/adma_dm_dst_axis_keep.sv
// AXIS destination data mover: descriptor FIFO, beat counter, registered output slice
// with byte-accurate TKEEP on the last beat, and a per-channel sink-stall timeout.
module adma_dm_dst_axis_keep #(
  parameter int DMA_CHN_NUM    = 4,
  parameter int MST_ID_W       = 5,
  parameter int ATX_LEN_W      = 8,
  parameter int DST_TDEST_W    = 2,
  parameter int ATX_DST_DATA_W = 256,
  parameter int ATX_NUM_OSTD   = DMA_CHN_NUM,
  parameter int TMO_W          = 16,
  localparam int ATX_DST_BYTE_AMT = ATX_DST_DATA_W / 8,
  localparam int DMA_CHN_NUM_W    = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1,
  localparam int BYTE_CNT_W       = $clog2(ATX_DST_BYTE_AMT)
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [DMA_CHN_NUM_W-1:0]        atx_chn_id,
  input  logic [DST_TDEST_W-1:0]          atx_tdest,
  input  logic [ATX_LEN_W-1:0]            atx_tlen,
  input  logic [BYTE_CNT_W-1:0]           atx_lbytes,
  input  logic                            atx_vld,
  output logic                            atx_rdy,
  input  logic [ATX_DST_DATA_W-1:0]       atx_wdata,
  input  logic                            atx_wdata_vld,
  output logic                            atx_wdata_rdy,
  input  logic [DMA_CHN_NUM*MST_ID_W-1:0] atx_id,
  input  logic [TMO_W-1:0]                atx_tmo,
  output logic [DMA_CHN_NUM-1:0]          atx_done,
  output logic [DMA_CHN_NUM-1:0]          atx_dst_err,
  adma_dm_dst_axis_keep_if.master         m_axis
);
  localparam int PTR_W = (ATX_NUM_OSTD > 1) ? $clog2(ATX_NUM_OSTD) : 1;
  localparam int CNT_W = $clog2(ATX_NUM_OSTD + 1);

  typedef struct packed {
    logic [DMA_CHN_NUM_W-1:0] chn;
    logic [DST_TDEST_W-1:0]   tdest;
    logic [ATX_LEN_W-1:0]     tlen;
    logic [BYTE_CNT_W-1:0]    lbytes;
  } desc_t;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(ATX_NUM_OSTD - 1)) ? '0 : p + 1'b1;
  endfunction

  // lbytes==0 on the last beat means a fully populated beat.
  function automatic logic [ATX_DST_BYTE_AMT-1:0] keep_f(input logic last,
                                                         input logic [BYTE_CNT_W-1:0] lb);
    keep_f = '1;
    if (last && lb != '0)
      for (int i = 0; i < ATX_DST_BYTE_AMT; i++) keep_f[i] = (i < int'(lb));
  endfunction

  desc_t                     fifo_q [ATX_NUM_OSTD];
  desc_t                     desc_in, head;
  logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]          fill_q;
  logic [ATX_LEN_W-1:0]      beat_cnt_q;
  logic                      full, head_vld, push, pop, accept, beat_last, slice_rdy;
  logic                      tvalid_q, tlast_q;
  logic [ATX_DST_DATA_W-1:0] tdata_q;
  logic [ATX_DST_BYTE_AMT-1:0] tkeep_q;
  logic [MST_ID_W-1:0]       tid_q;
  logic [DST_TDEST_W-1:0]    tdest_q;
  logic [DMA_CHN_NUM_W-1:0]  chn_q;
  logic [TMO_W-1:0]          tmo_cnt_q, tmo_cnt_d;
  logic                      stall, tmo_hit;

  assign desc_in   = '{chn: atx_chn_id, tdest: atx_tdest, tlen: atx_tlen, lbytes: atx_lbytes};
  assign head      = fifo_q[rd_ptr_q];
  assign full      = (fill_q == CNT_W'(ATX_NUM_OSTD));
  assign head_vld  = (fill_q != '0);
  assign slice_rdy = ~tvalid_q | m_axis.m_tready_i;
  assign atx_wdata_rdy = head_vld & slice_rdy;
  assign accept    = atx_wdata_vld & atx_wdata_rdy;
  assign beat_last = (beat_cnt_q == head.tlen);
  assign pop       = accept & beat_last;
  // A pop in the same cycle frees a slot, so a full FIFO can still take a descriptor.
  assign atx_rdy   = ~areset & (~full | pop);
  assign push      = atx_vld & atx_rdy;

  always_ff @(posedge aclk) begin
    if (push) fifo_q[wr_ptr_q] <= desc_in;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      beat_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase
      if (accept) beat_cnt_q <= beat_last ? '0 : beat_cnt_q + 1'b1;
    end
  end

  // Output slice
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tid_q    <= '0;
      tdest_q  <= '0;
      chn_q    <= '0;
    end else if (accept) begin
      tvalid_q <= 1'b1;
      tlast_q  <= beat_last;
      tdata_q  <= atx_wdata;
      tkeep_q  <= keep_f(beat_last, head.lbytes);
      tid_q    <= atx_id[int'(head.chn)*MST_ID_W +: MST_ID_W];
      tdest_q  <= head.tdest;
      chn_q    <= head.chn;
    end else if (m_axis.m_tready_i) begin
      tvalid_q <= 1'b0;
    end
  end

  // Stall timeout: counts cycles the current beat has been refused; fires once per beat.
  assign stall     = tvalid_q & ~m_axis.m_tready_i;
  assign tmo_cnt_d = stall ? ((&tmo_cnt_q) ? tmo_cnt_q : tmo_cnt_q + 1'b1) : '0;
  assign tmo_hit   = stall & (atx_tmo != '0) & (tmo_cnt_d == atx_tmo) & (tmo_cnt_q != atx_tmo);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end

  always_comb begin
    atx_done    = '0;
    atx_dst_err = '0;
    if (tvalid_q & m_axis.m_tready_i & tlast_q) atx_done[chn_q] = 1'b1;
    if (tmo_hit) atx_dst_err[chn_q] = 1'b1;
  end

  assign m_axis.m_tvalid_o = tvalid_q;
  assign m_axis.m_tlast_o  = tlast_q;
  assign m_axis.m_tdata_o  = tdata_q;
  assign m_axis.m_tkeep_o  = tkeep_q;
  assign m_axis.m_tstrb_o  = tkeep_q;
  assign m_axis.m_tid_o    = tid_q;
  assign m_axis.m_tdest_o  = tdest_q;
endmodule
